muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for a single-issue pipeline: one shift-add or
// restoring-division step per cycle, with sign handling, early-out bypasses and a stall handshake.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] srcA_i,
    input  logic [DATA_WIDTH-1:0] srcB_i,
    input  logic [4:0]            rd_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            rd_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [5:0]   LAST_ITER = 6'(W - 1);
    localparam logic [W-1:0] MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t       r_state, w_state_nxt;
    logic [5:0]   r_cnt;
    logic [2:0]   r_op;
    logic [4:0]   r_rd, r_rd_out;
    logic [W-1:0] r_hi, r_lo, r_b, r_result;
    logic         r_neg_a, r_neg_b;

    logic         w_accept, w_signed_a, w_signed_b, w_sa, w_sb;
    logic         w_div_zero, w_overflow, w_bypass, w_last;
    logic [W-1:0] w_mag_a, w_mag_b, w_bypass_res;
    logic [W:0]   w_sum, w_shift;
    logic [W-1:0] w_diff, w_hi_nxt, w_lo_nxt, w_quo, w_rem, w_final;
    logic [2*W-1:0] w_mul_step, w_prod;
    logic         w_ge;

    // Operand decode: r_hi/r_lo hold accumulator:multiplier for MUL, remainder:quotient for DIV.
    assign w_accept   = valid_i && !flush_i;
    assign w_signed_a = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    assign w_signed_b = op_i[2] ? ~op_i[0] : ~op_i[1];
    assign w_sa       = w_signed_a & srcA_i[W-1];
    assign w_sb       = w_signed_b & srcB_i[W-1];
    assign w_mag_a    = w_sa ? -srcA_i : srcA_i;
    assign w_mag_b    = w_sb ? -srcB_i : srcB_i;
    assign w_div_zero = op_i[2] && (srcB_i == '0);
    assign w_overflow = op_i[2] && !op_i[0] && (srcA_i == MOST_NEG) && (srcB_i == '1);
    assign w_bypass   = w_div_zero || w_overflow;
    assign w_bypass_res = w_div_zero ? (op_i[1] ? srcA_i : '1)
                                     : (op_i[1] ? '0 : srcA_i);
    assign w_last     = (r_cnt == LAST_ITER);

    // One iteration of each algorithm, plus sign correction of what the last iteration yields.
    always_comb begin
        w_sum      = {1'b0, r_hi} + {1'b0, r_b};
        w_mul_step = r_lo[0] ? {w_sum, r_lo[W-1:1]} : {1'b0, r_hi, r_lo[W-1:1]};
        w_shift    = {r_hi, r_lo[W-1]};
        w_ge       = (w_shift >= {1'b0, r_b});
        w_diff     = w_shift[W-1:0] - r_b;
        if (r_state == MUL) begin
            w_hi_nxt = w_mul_step[2*W-1:W];
            w_lo_nxt = w_mul_step[W-1:0];
        end else begin
            w_hi_nxt = w_ge ? w_diff : w_shift[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], w_ge};
        end
        w_prod = (r_neg_a ^ r_neg_b) ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
        w_quo  = (r_neg_a ^ r_neg_b) ? -w_lo_nxt : w_lo_nxt;
        w_rem  = r_neg_a ? -w_hi_nxt : w_hi_nxt;
        if (r_op[2])
            w_final = r_op[1] ? w_rem : w_quo;
        else
            w_final = (r_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            IDLE: begin
                stall_o = w_accept;
                if (w_accept)
                    w_state_nxt = w_bypass ? DONE : (op_i[2] ? DIV : MUL);
            end
            MUL, DIV: begin
                stall_o = 1'b1;
                if (flush_i)
                    w_state_nxt = IDLE;
                else if (w_last)
                    w_state_nxt = DONE;
            end
            DONE: begin
                done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_rd_out <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_i;
                        r_rd    <= rd_i;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_lo    <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_neg_a <= w_sa;
                        r_neg_b <= w_sb;
                        if (w_bypass) begin
                            r_result <= w_bypass_res;
                            r_rd_out <= rd_i;
                        end
                    end
                end
                MUL, DIV: begin
                    if (!flush_i) begin
                        r_hi  <= w_hi_nxt;
                        r_lo  <= w_lo_nxt;
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_result <= w_final;
                            r_rd_out <= r_rd;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign rd_o     = r_rd_out;

endmodule
